cpu_exec_ctrl: RTL and testbench

Execution sequencer for the single-cycle CPU core. It generates the core's global_en from host commands: free-run, step N instructions, and pause. It stops the core on an ebreak instruction (32'h00100073) and, optionally, on a PC breakpoint. It sits between the debug/host interface and the CPU, and also keeps cycle and retired-instruction counters.

---
 rtl/cpu_exec_ctrl_if.sv | 15 +
 rtl/cpu_exec_ctrl.sv | 140 ++++++++++++++
 tb/tb_cpu_exec_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_exec_ctrl_if.sv
// Host command channel of cpu_exec_ctrl: the host drives the command fields and
// the sequencer answers with cmd_ready.
interface cpu_exec_ctrl_if #(
  parameter int STEP_W = 16
) ();
  // valid/ready: a command transfers on any posedge with cmd_valid && cmd_ready;
  // the host holds cmd_op/cmd_arg stable while cmd_valid is high and not yet accepted.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/cpu_exec_ctrl.sv
// Execution sequencer: turns host RUN/STEP/PAUSE/CLEAR commands into the core's global_en,
// halts on ebreak, counts enabled cycles and commits. Define BREAKPOINT_EN for PC breakpoints.
module cpu_exec_ctrl #(
  parameter int          STEP_W    = 16,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] HALT_INST = 32'h00100073
) (
  input  logic                clk,
  input  logic                rst,
  cpu_exec_ctrl_if.slave      cmd,
  input  logic [31:0]         cur_pc,
  input  logic [31:0]         cur_inst,
  input  logic                commit,
  input  logic                bp_en,
  input  logic [31:0]         bp_pc,
  output logic                global_en,
  output logic [1:0]          state,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    inst_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_STEP  = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic              active;
  logic              accept;
  logic              clear_cnt;
  logic              halt_hit;
  logic              bp_hit;
  logic              start_cmd;

  assign active    = (state_q == S_RUN) || (state_q == S_STEP);
  assign halt_hit  = active && (cur_inst == HALT_INST);
  assign start_cmd = (state_q == S_IDLE) && accept &&
                     ((cmd.cmd_op == OP_RUN) || (cmd.cmd_op == OP_STEP));

`ifdef BREAKPOINT_EN
  // skip_bp lets a RUN/STEP issued while parked on bp_pc execute that instruction once.
  logic skip_bp_q, skip_bp_d;

  assign bp_hit = active && bp_en && (cur_pc == bp_pc) && !skip_bp_q;

  always_comb begin
    skip_bp_d = skip_bp_q;
    if (start_cmd)      skip_bp_d = 1'b1;
    else if (global_en) skip_bp_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) skip_bp_q <= 1'b0;
    else      skip_bp_q <= skip_bp_d;
  end
`else
  logic unused_bp;

  assign bp_hit    = 1'b0;
  assign unused_bp = &{1'b0, bp_en, bp_pc, cur_pc};
`endif

  assign global_en     = active && !bp_hit;
  assign cmd.cmd_ready = (state_q != S_STEP);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign clear_cnt     = accept && (cmd.cmd_op == OP_CLEAR);
  assign state         = state_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (accept && cmd.cmd_op == OP_RUN) begin
          state_d = S_RUN;
        end else if (accept && cmd.cmd_op == OP_STEP) begin
          state_d     = S_STEP;
          remaining_d = (cmd.cmd_arg == '0) ? STEP_W'(1) : cmd.cmd_arg;
        end
      end
      S_RUN: begin
        // Stop sources in priority order: breakpoint, ebreak, host PAUSE.
        if (bp_hit) begin
          state_d     = S_IDLE;
          remaining_d = '0;
        end else if (halt_hit) begin
          state_d = S_HALTED;
        end else if (accept && cmd.cmd_op == OP_PAUSE) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (bp_hit) begin
          state_d     = S_IDLE;
          remaining_d = '0;
        end else begin
          remaining_d = remaining_q - STEP_W'(1);
          if (halt_hit)                       state_d = S_HALTED;
          else if (remaining_q == STEP_W'(1)) state_d = S_IDLE;
        end
      end
      S_HALTED: begin
        if (clear_cnt) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Commit lags global_en by one cycle, so it is counted independently of state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      if (clear_cnt)      cycle_cnt <= '0;
      else if (global_en) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (clear_cnt)      inst_cnt  <= '0;
      else if (commit)    inst_cnt  <= inst_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Self-checking bench for cpu_exec_ctrl: directed scenarios plus randomized commands, all
// compared every cycle against an event-level reference model of the sequencer.
module tb_cpu_exec_ctrl;
  localparam int          STEP_W = 16;
  localparam int          CNT_W  = 32;
  localparam logic [31:0] HALT   = 32'h00100073;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] BP_PC  = 32'h00400008;
  localparam logic [31:0] PC0    = 32'h00001000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      cur_pc = PC0;
  logic [31:0]      cur_inst = NOP;
  logic             commit = 1'b0;
  logic             bp_en = 1'b0;
  logic [31:0]      bp_pc = BP_PC;
  logic             global_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] inst_cnt;

  cpu_exec_ctrl_if #(.STEP_W(STEP_W)) cif ();

  cpu_exec_ctrl #(.STEP_W(STEP_W), .CNT_W(CNT_W), .HALT_INST(HALT)) dut (
    .clk(clk), .rst(rst), .cmd(cif.slave), .cur_pc(cur_pc), .cur_inst(cur_inst),
    .commit(commit), .bp_en(bp_en), .bp_pc(bp_pc), .global_en(global_en),
    .state(state), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 stepping, 3 halted; left = steps still owed.
  int               m_mode;
  int               m_left;
  bit               m_skip;
  logic [CNT_W-1:0] m_cyc;
  logic [CNT_W-1:0] m_ret;
  bit               prev_en;
  logic [CNT_W+3:0] exp_q[$];

  bit               obs_en;
  logic [1:0]       obs_state;
  logic [CNT_W-1:0] obs_cyc;
  logic [CNT_W-1:0] obs_ret;

  function automatic void model_reset();
    m_mode = 0; m_left = 0; m_skip = 0; m_cyc = '0; m_ret = '0; prev_en = 0;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    cif.cmd_valid = 1'b0;
    commit = 1'b0;
    repeat (n) @(posedge clk);
    model_reset();
  endtask

  // One clock: drive at negedge, compare at negedge+1, advance model, wait for posedge.
  task automatic tick(input bit v, input logic [1:0] op, input logic [STEP_W-1:0] arg,
                      input logic [31:0] inst, input logic [31:0] pc, input bit cm);
    bit running, bp, en, ready, acc, halt;
    logic [CNT_W+3:0] exp_vec, got_vec;
    @(negedge clk);
    rst = 1'b1;
    cif.cmd_valid = v; cif.cmd_op = op; cif.cmd_arg = arg;
    cur_inst = inst; cur_pc = pc; commit = cm;
    #1;
    running = (m_mode == 1) || (m_mode == 2);
`ifdef BREAKPOINT_EN
    bp = running && bp_en && (pc == bp_pc) && !m_skip;
`else
    bp = 1'b0;
`endif
    en    = running && !bp;
    ready = (m_mode != 2);
    acc   = v && ready;
    halt  = running && (inst == HALT);
    exp_q.push_back({en, ready, 2'(m_mode), m_cyc});
    got_vec = {global_en, cif.cmd_ready, state, cycle_cnt};
    exp_vec = exp_q.pop_front();
    check("global_en", 64'(got_vec[CNT_W+3]), 64'(exp_vec[CNT_W+3]));
    check("cmd_ready", 64'(got_vec[CNT_W+2]), 64'(exp_vec[CNT_W+2]));
    check("state", 64'(got_vec[CNT_W+1:CNT_W]), 64'(exp_vec[CNT_W+1:CNT_W]));
    check("cycle_cnt", 64'(got_vec[CNT_W-1:0]), 64'(exp_vec[CNT_W-1:0]));
    check("inst_cnt", 64'(inst_cnt), 64'(m_ret));
    obs_en = global_en; obs_state = state; obs_cyc = cycle_cnt; obs_ret = inst_cnt;
    // Counters: CLEAR wins over increments.
    if (acc && op == 2'b11) begin
      m_cyc = '0; m_ret = '0;
    end else begin
      if (en) m_cyc = m_cyc + 1;
      if (cm) m_ret = m_ret + 1;
    end
    if (en) m_skip = 0;
    if (bp) begin
      m_mode = 0; m_left = 0;
    end else if (halt) begin
      m_mode = 3;
    end else if (m_mode == 2) begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = 0;
    end else if (acc) begin
      if (m_mode == 0 && op == 2'b00) begin
        m_mode = 1; m_skip = 1;
      end else if (m_mode == 0 && op == 2'b01) begin
        m_mode = 2; m_skip = 1; m_left = (arg == 0) ? 1 : int'(arg);
      end else if (m_mode == 1 && op == 2'b10) begin
        m_mode = 0;
      end else if (m_mode == 3 && op == 2'b11) begin
        m_mode = 0;
      end
    end
    prev_en = en;
    @(posedge clk);
  endtask

  task automatic idle(input logic [31:0] inst);
    tick(1'b0, 2'b00, '0, inst, PC0, prev_en);
  endtask

  task automatic send(input logic [1:0] op, input logic [STEP_W-1:0] arg);
    tick(1'b1, op, arg, NOP, PC0, prev_en);
  endtask

  initial begin
    int en_n;
    cif.cmd_valid = 1'b0; cif.cmd_op = 2'b00; cif.cmd_arg = '0;
    model_reset();
    do_reset(2);

    // Reset state
    idle(NOP);
    check("rst_state", 64'(obs_state), 64'(0));
    check("rst_en", 64'(obs_en), 64'(0));
    check("rst_cnt", 64'({obs_cyc, obs_ret}), 64'(0));

    // STEP 3
    send(2'b01, 16'd3);
    en_n = 0;
    for (int i = 0; i < 6; i++) begin
      idle(NOP);
      en_n += int'(obs_en);
    end
    check("step3_en_cycles", 64'(en_n), 64'(3));
    check("step3_state", 64'(obs_state), 64'(0));
    check("step3_cycle_cnt", 64'(obs_cyc), 64'(3));
    check("step3_inst_cnt", 64'(obs_ret), 64'(3));

    // STEP 0 behaves as STEP 1
    send(2'b11, '0);
    send(2'b01, 16'd0);
    en_n = 0;
    for (int i = 0; i < 4; i++) begin
      idle(NOP);
      en_n += int'(obs_en);
    end
    check("step0_en_cycles", 64'(en_n), 64'(1));
    check("step0_cycle_cnt", 64'(obs_cyc), 64'(1));

    // RUN, ebreak on the 5th enabled cycle
    send(2'b11, '0);
    send(2'b00, '0);
    for (int i = 1; i <= 5; i++) idle((i == 5) ? HALT : NOP);
    check("halt_en_on_ebreak", 64'(obs_en), 64'(1));
    idle(NOP);
    check("halt_state", 64'(obs_state), 64'(3));
    check("halt_en_after", 64'(obs_en), 64'(0));
    send(2'b00, '0);
    idle(NOP);
    check("halt_ignores_run", 64'(obs_state), 64'(3));
    send(2'b11, '0);
    idle(NOP);
    check("halt_clear_state", 64'(obs_state), 64'(0));
    check("halt_clear_cnt", 64'({obs_cyc, obs_ret}), 64'(0));

    // RUN, PAUSE after 10 enabled cycles
    send(2'b00, '0);
    for (int i = 0; i < 10; i++) idle(NOP);
    send(2'b10, '0);
    check("pause_accept_en", 64'(obs_en), 64'(1));
    idle(NOP);
    check("pause_state", 64'(obs_state), 64'(0));
    check("pause_cycle_cnt", 64'(obs_cyc), 64'(11));

    // Reset in the middle of a run
    send(2'b00, '0);
    for (int i = 0; i < 3; i++) idle(NOP);
    do_reset(1);
    idle(NOP);
    check("midrun_rst_en", 64'(obs_en), 64'(0));
    check("midrun_rst_state", 64'(obs_state), 64'(0));

`ifdef BREAKPOINT_EN
    bp_en = 1'b1;
    tick(1'b1, 2'b00, '0, NOP, 32'h00400000, prev_en);
    tick(1'b0, 2'b00, '0, NOP, 32'h00400000, prev_en);
    tick(1'b0, 2'b00, '0, NOP, 32'h00400004, prev_en);
    tick(1'b0, 2'b00, '0, NOP, 32'h00400008, prev_en);
    check("bp_stop_en", 64'(obs_en), 64'(0));
    tick(1'b0, 2'b00, '0, NOP, 32'h00400008, prev_en);
    check("bp_stop_state", 64'(obs_state), 64'(0));
    tick(1'b1, 2'b00, '0, NOP, 32'h00400008, prev_en);
    tick(1'b0, 2'b00, '0, NOP, 32'h00400008, prev_en);
    check("bp_resume_en", 64'(obs_en), 64'(1));
    tick(1'b0, 2'b00, '0, NOP, 32'h0040000c, prev_en);
    check("bp_continue_en", 64'(obs_en), 64'(1));
    bp_en = 1'b0;
`endif

    // Randomized commands, ebreaks, breakpoint hits and commit patterns
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end else begin
        bp_en = 1'($urandom_range(0, 1));
        tick(($urandom_range(0, 3) == 0),
             2'($urandom_range(0, 3)),
             STEP_W'($urandom_range(0, 6)),
             ($urandom_range(0, 40) == 0) ? HALT : $urandom,
             ($urandom_range(0, 3) == 0) ? bp_pc : $urandom,
             ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : prev_en);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
